// File: rtl/usb_fs_line_tx_if.sv
// Byte-stream handshake between packet logic and the full-speed USB line transmitter.
interface usb_fs_line_tx_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       tx_busy_o;

  modport master (output tx_valid_i, output tx_data_i, input tx_ready_o, input tx_busy_o);
  modport slave  (input tx_valid_i, input tx_data_i, output tx_ready_o, output tx_busy_o);
endinterface

// File: rtl/usb_fs_line_tx.sv
// Full-speed USB line transmitter: SYNC, NRZI with bit stuffing (LSB first), then EOP.
// Line outputs are registered; each USB bit lasts BIT_SAMPLES clocks.
module usb_fs_line_tx #(
  parameter int BIT_SAMPLES = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  usb_fs_line_tx_if.slave  tx,
  output logic             tx_en_o,
  output logic             dp_tx_o,
  output logic             dn_tx_o
);
  localparam int            CW       = $clog2(BIT_SAMPLES);
  localparam logic [CW-1:0] LAST     = CW'(BIT_SAMPLES - 1);
  localparam logic [7:0]    SYNC_PAT = 8'h80;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [6:0]    sr, sr_d;
  logic [2:0]    ones, ones_d;
  logic          en_d, dp_d, dn_d;
  logic          strobe, send, tx_bit, load;

  assign strobe        = (cnt == LAST);
  assign tx.tx_ready_o = load;
  assign tx.tx_busy_o  = tx_en_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sr      <= '0;
      ones    <= '0;
      tx_en_o <= 1'b0;
      dp_tx_o <= 1'b1;
      dn_tx_o <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      sr      <= sr_d;
      ones    <= ones_d;
      tx_en_o <= en_d;
      dp_tx_o <= dp_d;
      dn_tx_o <= dn_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sr_d    = sr;
    ones_d  = ones;
    en_d    = tx_en_o;
    dp_d    = dp_tx_o;
    dn_d    = dn_tx_o;
    send    = 1'b0;
    tx_bit  = 1'b1;
    load    = 1'b0;

    if (state != IDLE) cnt_d = strobe ? '0 : cnt + 1'b1;

    case (state)
      IDLE: begin
        if (tx.tx_valid_i) begin
          state_d = SYNC;
          cnt_d   = '0;
          idx_d   = '0;
          en_d    = 1'b1;
          send    = 1'b1;
          tx_bit  = SYNC_PAT[0];
        end
      end
      SYNC: begin
        if (strobe) begin
          if (idx == 3'd7) load = 1'b1;
          else begin
            idx_d  = idx + 3'd1;
            send   = 1'b1;
            tx_bit = SYNC_PAT[idx + 3'd1];
          end
        end
      end
      DATA: begin
        if (strobe) begin
          // Stuff takes priority, so a stuff owed after bit 7 goes out before the next load.
          if (ones == 3'd6) begin
            dp_d   = ~dp_tx_o;
            dn_d   = ~dn_tx_o;
            ones_d = '0;
          end else if (idx == 3'd7) begin
            load = 1'b1;
          end else begin
            idx_d  = idx + 3'd1;
            sr_d   = {1'b0, sr[6:1]};
            send   = 1'b1;
            tx_bit = sr[0];
            ones_d = sr[0] ? ones + 3'd1 : 3'd0;
          end
        end
      end
      EOP_SE0: begin
        if (strobe) begin
          if (idx == 3'd1) begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dn_d    = 1'b0;
          end else idx_d = idx + 3'd1;
        end
      end
      EOP_J: begin
        if (strobe) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (tx.tx_valid_i) begin
        state_d = DATA;
        sr_d    = tx.tx_data_i[7:1];
        idx_d   = '0;
        send    = 1'b1;
        tx_bit  = tx.tx_data_i[0];
        // The ones run carries across byte boundaries but starts fresh after SYNC.
        if (!tx.tx_data_i[0])  ones_d = '0;
        else if (state == DATA) ones_d = ones + 3'd1;
        else                   ones_d = 3'd1;
      end else begin
        state_d = EOP_SE0;
        idx_d   = '0;
        dp_d    = 1'b0;
        dn_d    = 1'b0;
      end
    end

    if (send && !tx_bit) begin
      dp_d = ~dp_tx_o;
      dn_d = ~dn_tx_o;
    end
  end
endmodule

// File: tb/tb_usb_fs_line_tx.sv
// Directed bench for usb_fs_line_tx with BIT_SAMPLES=4: per-cycle line waveform,
// enable/busy window and ready pulse positions checked against hand-derived tables.
module tb_usb_fs_line_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en, dp, dn;
  int   n_tests = 0;
  int   n_fail  = 0;

  byte  ln     [0:199];
  logic en_s   [0:199];
  logic busy_s [0:199];
  logic rdy_s  [0:199];

  always #5 clk = ~clk;

  usb_fs_line_tx_if bus();

  usb_fs_line_tx #(.BIT_SAMPLES(4)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .tx      (bus),
    .tx_en_o (en),
    .dp_tx_o (dp),
    .dn_tx_o (dn)
  );

  function automatic byte sym();
    if (dp === 1'b1 && dn === 1'b0) return "J";
    if (dp === 1'b0 && dn === 1'b1) return "K";
    if (dp === 1'b0 && dn === 1'b0) return "0";
    return "X";
  endfunction

  // Starts a packet in the current (negedge) cycle t and records cycles t..t+last+1.
  task automatic run_pkt(input string name, input logic [7:0] b0, input logic [7:0] b1,
                         input int nbytes, input string exp, input int r0, input int r1, input int r2);
    int  last, sent, bad, first, en_bad, busy_bad, rdy_bad, en_cnt;
    logic want;
    last = 4 * exp.len();
    sent = 0;
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = b0;
    for (int k = 0; k <= last + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
        if (rdy_s[k-1]) begin
          sent++;
          if (sent < nbytes) bus.tx_data_i = b1;
          else bus.tx_valid_i = 1'b0;
        end
      end
      ln[k]     = sym();
      en_s[k]   = en;
      busy_s[k] = bus.tx_busy_o;
      rdy_s[k]  = bus.tx_ready_o;
    end

    n_tests++;
    if (en_s[0] !== 1'b0 || ln[0] != "J") begin
      n_fail++;
      $display("FAIL %s_idle_start: en=%b line=%c, expected en=0 line=J", name, en_s[0], ln[0]);
    end

    bad = 0; first = -1;
    for (int k = 1; k <= last; k++)
      if (ln[k] != exp[(k-1)/4]) begin
        if (bad == 0) first = k;
        bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_line: %0d cycles wrong, first at t+%0d got %c expected %c",
               name, bad, first, ln[first], exp[(first-1)/4]);
    end

    en_bad = 0; busy_bad = 0; en_cnt = 0;
    for (int k = 0; k <= last + 1; k++) begin
      want = (k >= 1 && k <= last);
      if (en_s[k] === 1'b1) en_cnt++;
      if (en_s[k] !== want) en_bad++;
      if (busy_s[k] !== want) busy_bad++;
    end
    n_tests++;
    if (en_cnt != last) begin
      n_fail++;
      $display("FAIL %s_en_cycles: tx_en high %0d cycles, expected %0d", name, en_cnt, last);
    end
    n_tests++;
    if (en_bad != 0) begin
      n_fail++;
      $display("FAIL %s_en_window: %0d cycles differ from window t+1..t+%0d", name, en_bad, last);
    end
    n_tests++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy_window: %0d cycles differ from window t+1..t+%0d", name, busy_bad, last);
    end

    rdy_bad = 0; first = -1;
    for (int k = 0; k <= last + 1; k++) begin
      want = (k == r0 || k == r1 || k == r2);
      if (rdy_s[k] !== want) begin
        if (rdy_bad == 0) first = k;
        rdy_bad++;
      end
    end
    n_tests++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL %s_ready: %0d cycles wrong, first at t+%0d got %b (expected pulses at %0d %0d %0d)",
               name, rdy_bad, first, rdy_s[first], r0, r1, r2);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.tx_valid_i = i[0];
      bus.tx_data_i  = 8'hFF;
      #1;
      n_tests++;
      if (en !== 1'b0 || dp !== 1'b1 || dn !== 1'b0 || bus.tx_ready_o !== 1'b0 || bus.tx_busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: en=%b dp=%b dn=%b rdy=%b busy=%b, expected 0 1 0 0 0",
                 i, en, dp, dn, bus.tx_ready_o, bus.tx_busy_o);
      end
    end
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (en !== 1'b0 || dp !== 1'b1 || dn !== 1'b0 || bus.tx_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: en=%b dp=%b dn=%b busy=%b, expected 0 1 0 0",
               en, dp, dn, bus.tx_busy_o);
    end
  endtask

  task automatic test_one_zero();
    run_pkt("byte00", 8'h00, 8'h00, 1, "KJKJKJKKJKJKJKJK00J", 32, 64, -1);
  endtask

  task automatic test_all_ones();
    run_pkt("byteFF", 8'hFF, 8'h00, 1, "KJKJKJKKKKKKKKJJJ00J", 32, 68, -1);
  endtask

  task automatic test_two_bytes();
    logic [23:0] dec;
    byte prev, s;
    run_pkt("C3A5", 8'hC3, 8'hA5, 2, "KJKJKJKKKKJKJKKKKJJKJJKK00J", 32, 64, 96);
    prev = "J";
    for (int i = 0; i < 24; i++) begin
      s = ln[4*i + 2];
      dec[i] = (s == prev);
      prev = s;
    end
    n_tests++;
    if (dec !== 24'hA5C380) begin
      n_fail++;
      $display("FAIL C3A5_decode: got %h expected a5c380", dec);
    end
  endtask

  task automatic test_stuff_boundary();
    run_pkt("F03F", 8'hF0, 8'h3F, 2, "KJKJKJKKJKJKKKKKKKJJJJJKJ00J", 32, 64, 100);
  endtask

  // Second packet starts in the first IDLE cycle after the first one; 0xFC owes a trailing stuff bit.
  task automatic test_back_to_back();
    run_pkt("b2b_00", 8'h00, 8'h00, 1, "KJKJKJKKJKJKJKJK00J", 32, 64, -1);
    run_pkt("b2b_FC", 8'hFC, 8'h00, 1, "KJKJKJKKJKKKKKKKJ00J", 32, 68, -1);
  endtask

  task automatic test_reset_mid();
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'h00;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_tests++;
    if (en !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_active: en=%b at t+45, expected 1", en);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (en !== 1'b0 || dp !== 1'b1 || dn !== 1'b0 || bus.tx_busy_o !== 1'b0 || bus.tx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_immediate: en=%b dp=%b dn=%b busy=%b rdy=%b, expected 0 1 0 0 0",
               en, dp, dn, bus.tx_busy_o, bus.tx_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (en !== 1'b0 || dp !== 1'b1 || dn !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_held: en=%b dp=%b dn=%b, expected 0 1 0", en, dp, dn);
    end
    rstn = 1'b1;
    run_pkt("after_reset", 8'h00, 8'h00, 1, "KJKJKJKKJKJKJKJK00J", 32, 64, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    test_reset();
    test_one_zero();
    test_all_ones();
    test_two_bytes();
    test_stuff_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_fs_line_tx.md
Name: usb_fs_line_tx

Overview:
- Full-speed USB line transmitter: takes a byte stream and drives the D+/D- pads.
- Per packet it generates SYNC, NRZI-encodes data LSB first with bit stuffing, then appends EOP.
- It is the transmit-side counterpart of the line receiver. It sits between packet-level logic and the uio pad outputs/enables in the TT wrapper.

Parameters:
- BIT_SAMPLES, 4, clk_i cycles per USB bit (48 MHz clk_i / 12 Mbit/s); legal values 3..16.

Ports:
- clk_i  input  1  system clock (BIT_SAMPLES x 12 MHz)
- rstn_i  input  1  asynchronous active-low reset
- tx_valid_i  input  1  byte available; high in IDLE starts a packet
- tx_data_i  input  8  byte to send, sampled when tx_ready_o=1
- tx_ready_o  output  1  one-cycle pulse; byte on tx_data_i consumed this cycle if tx_valid_i=1
- tx_busy_o  output  1  high from packet start until EOP complete
- tx_en_o  output  1  pad output enable for D+/D-
- dp_tx_o  output  1  D+ drive value
- dn_tx_o  output  1  D- drive value

Behaviour:
- Reset (async, immediate, also mid-packet): tx_en_o=0, dp_tx_o=1, dn_tx_o=0 (J), tx_ready_o=0, tx_busy_o=0, state IDLE, all counters cleared.
- Line states: J = dp1/dn0, K = dp0/dn1, SE0 = dp0/dn0. All line outputs are registered.
- Bit timer: counts 0..BIT_SAMPLES-1 while not IDLE. The bit strobe fires at count BIT_SAMPLES-1, and the line changes on the cycle after the strobe. Each bit lasts exactly BIT_SAMPLES cycles.
- NRZI: a 0 bit toggles the line (J<->K); a 1 bit holds it. The NRZI reference is J at packet start.
- State IDLE:
  - When tx_valid_i=1 at cycle t, enter SYNC and clear the bit timer.
  - At t+1: tx_en_o=1, tx_busy_o=1, line=K.
- State SYNC: sends 8'h80 LSB first, i.e. KJKJKJKK. SYNC is never stuffed.
- State DATA:
  - Byte load occurs on the strobe ending the last SYNC bit, or the last bit of the previous byte (including any trailing stuff bit).
  - At that cycle tx_ready_o=1 for exactly one cycle.
  - If tx_valid_i=1, tx_data_i is loaded into the shift register and DATA continues.
  - If tx_valid_i=0, go to EOP_SE0 instead.
- Bit stuffing:
  - The ones counter is cleared on entering DATA and persists across byte boundaries.
  - After 6 consecutive transmitted 1s, one stuff 0 (a toggle) is inserted and the counter clears. The shift register does not advance during the stuff bit.
  - A stuff bit owed after the final data bit is sent before EOP.
- EOP:
  - EOP_SE0: SE0 for 2 bit times.
  - EOP_J: J for 1 bit time.
  - Then tx_en_o=0 and tx_busy_o=0 on the following cycle, and return to IDLE.
  - tx_valid_i is ignored during EOP.
  - A new packet may start the cycle after return to IDLE.
- tx_ready_o is never asserted outside the byte-load cycle.
- The first tx_ready_o of a packet occurs 8*BIT_SAMPLES cycles after the start cycle t.

Test Plan:
1. Assert rstn_i=0 -> tx_en_o=0, dp=1, dn=0, tx_ready_o=0, tx_busy_o=0. Toggling tx_valid_i during reset has no effect.
2. One byte 0x00, BIT_SAMPLES=4 -> line shows K J K J K J K K (SYNC), J K J K J K J K (data), SE0 for 8 cycles, J for 4 cycles. tx_en_o high for exactly 76 cycles. tx_ready_o pulses at cycles t+32 (consume 0x00) and t+64 (valid low -> EOP).
3. One byte 0xFF -> 6 held bits, one stuff toggle, 2 held bits: 9 data bit times. tx_en_o high for 80 cycles.
4. Bytes 0xC3, 0xA5 with valid held, then dropped -> tx_ready_o pulses at t+32, t+64, t+96 (no stuffing). Decoded NRZI bit stream equals SYNC then C3, A5 LSB first.
5. Bytes 0xF0, 0x3F -> ones run spans the boundary (4+2). A stuff bit is inserted after bit 1 of 0x3F, and the second tx_ready_o is delayed by 0 cycles. The end-of-packet ready is delayed by 4 cycles (t+100).
6. Reset asserted mid-DATA (cycle t+45) -> same cycle outputs J, tx_en_o=0. After release with tx_valid_i=1, a fresh SYNC starts with the first K.
